// File: rtl/vgafifo_to_sdram_writer.sv
// Frame loader: pops 8-bit pixels from the decoded-image FIFO, packs pairs into 16-bit words and writes one frame over Avalon-MM.
// Five cycles per word with no stalls; an empty FIFO or an asserted waitrequest stalls the sequence in place.
module vgafifo_to_sdram_writer #(
    parameter int H_PIXELS = 1024,
    parameter int V_LINES  = 768
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSTART,
    input  logic [5:0]  iFRAME_ID,
    output logic        oFIFO_RREQ,
    input  logic [7:0]  iFIFO_RDATA,
    input  logic        iFIFO_EMPTY,
    input  logic        iWAIT_REQUEST,
    output logic        oWR_EN,
    output logic [24:0] oWR_ADDR,
    output logic [15:0] oWR_DATA,
    output logic        oBUSY,
    output logic        oDONE
);

    localparam logic [8:0] COL_LAST  = 9'(H_PIXELS / 2 - 1);
    localparam logic [9:0] LINE_LAST = 10'(V_LINES - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ_LO,
        CAP_LO,
        REQ_HI,
        CAP_HI,
        WRITE
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  frame_q, frame_d;
    logic [9:0]  line_q, line_d;
    logic [8:0]  col_q, col_d;
    logic [7:0]  lo_q, lo_d;
    logic        wr_en_q, wr_en_d;
    logic [24:0] wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        rreq_c;
    logic        accept_c;

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        line_d    = line_q;
        col_d     = col_q;
        lo_d      = lo_q;
        wr_en_d   = wr_en_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        done_d    = done_q;
        rreq_c    = 1'b0;
        accept_c  = wr_en_q && !iWAIT_REQUEST;

        case (state_q)
            IDLE: begin
                if (iSTART) begin
                    frame_d = iFRAME_ID;
                    line_d  = '0;
                    col_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = REQ_LO;
                end
            end
            REQ_LO: begin
                if (!iFIFO_EMPTY) begin
                    rreq_c  = 1'b1;
                    state_d = CAP_LO;
                end
            end
            CAP_LO: begin
                // Non-show-ahead FIFO: data for the previous request is valid now.
                lo_d    = iFIFO_RDATA;
                state_d = REQ_HI;
            end
            REQ_HI: begin
                if (!iFIFO_EMPTY) begin
                    rreq_c  = 1'b1;
                    state_d = CAP_HI;
                end
            end
            CAP_HI: begin
                wr_en_d   = 1'b1;
                wr_addr_d = {frame_q, line_q, col_q};
                wr_data_d = {iFIFO_RDATA, lo_q};
                state_d   = WRITE;
            end
            WRITE: begin
                if (accept_c) begin
                    wr_en_d = 1'b0;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (line_q == LINE_LAST) begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            line_d  = line_q + 10'd1;
                            state_d = REQ_LO;
                        end
                    end else begin
                        col_d   = col_q + 9'd1;
                        state_d = REQ_LO;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q   <= IDLE;
            frame_q   <= '0;
            line_q    <= '0;
            col_q     <= '0;
            lo_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            line_q    <= line_d;
            col_q     <= col_d;
            lo_q      <= lo_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Gated by reset so an abort never costs a pixel from the FIFO.
    assign oFIFO_RREQ = rreq_c && !iRST;
    assign oWR_EN     = wr_en_q;
    assign oWR_ADDR   = wr_addr_q;
    assign oWR_DATA   = wr_data_q;
    assign oBUSY      = busy_q;
    assign oDONE      = done_q;

endmodule
